gate_sweep_ctrl: RTL



---
 rtl/gate_sweep_ctrl_if.sv | 38 +++
 rtl/gate_sweep_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// Bundles the control-side and gate-side signals of gate_sweep_ctrl.
// err_cnt exists only when GATE_SWEEP_ERRCNT_EN is defined.
interface gate_sweep_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic       start;
    logic       p;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] tt;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    // A zero-width failure counter is meaningless.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("gate_sweep_ctrl_if: CNT_W must be at least 1");
    end

    modport slave (
        input  start, p,
        output a, b, busy, done, pass, tt
`ifdef GATE_SWEEP_ERRCNT_EN
        , output err_cnt
`endif
    );

    modport master (
        output start, p,
        input  a, b, busy, done, pass, tt
`ifdef GATE_SWEEP_ERRCNT_EN
        , input err_cnt
`endif
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through 00/01/10/11, samples P after each dwell and checks the truth table.
// Optional saturating failed-sweep counter enabled by GATE_SWEEP_ERRCNT_EN.
module gate_sweep_ctrl #(
    parameter int unsigned DWELL  = 4,
    parameter logic [3:0]  EXPECT = 4'b0110,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_sweep_ctrl_if.slave bus
);
    localparam int unsigned DW_W = $clog2(DWELL + 1);

    // A zero dwell would never sample P.
    if (DWELL < 1 || CNT_W < 1) begin : g_param_check
        $error("gate_sweep_ctrl: DWELL and CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      vec;
    logic [DW_W-1:0] cnt;
    logic            a_q;
    logic            b_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [3:0]      tt_q;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [CNT_W-1:0] err_q;
`endif

    // Sequencer: state, vector/dwell counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec    <= 2'd0;
            cnt    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            tt_q   <= 4'b0000;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= DRIVE;
                        vec    <= 2'd0;
                        cnt    <= '0;
                        tt_q   <= 4'b0000;
                        pass_q <= 1'b0;
                        busy_q <= 1'b1;
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt == DW_W'(DWELL - 1)) begin
                        tt_q[vec] <= bus.p;
                        cnt       <= '0;
                        if (vec == 2'd3) begin
                            state <= CHECK;
                            a_q   <= 1'b0;
                            b_q   <= 1'b0;
                        end else begin
                            vec          <= vec + 2'd1;
                            {a_q, b_q}   <= vec + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + DW_W'(1);
                    end
                end
                CHECK: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (tt_q == EXPECT);
`ifdef GATE_SWEEP_ERRCNT_EN
                    if ((tt_q != EXPECT) && (err_q != {CNT_W{1'b1}})) begin
                        err_q <= err_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.pass = pass_q;
    assign bus.tt   = tt_q;
`ifdef GATE_SWEEP_ERRCNT_EN
    assign bus.err_cnt = err_q;
`endif
endmodule
